// File: rtl/rv32i_memoryaccess_if.sv
// Pipelined Wishbone-style data-memory bus used by the memory-access stage.
interface rv32i_memoryaccess_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_ack;
  logic        wb_stall;
  logic [31:0] wb_rdata;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    input  wb_ack, wb_stall, wb_rdata
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    output wb_ack, wb_stall, wb_rdata
  );
endinterface

// File: rtl/rv32i_memoryaccess.sv
// rv32i memory-access stage: issues aligned loads/stores on the data bus,
// extracts/extends load data and passes other instructions to writeback.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no bus cycle open; stage may capture a new instruction
// ST_REQ  | cyc/stb asserted, waiting for the slave to accept (stall=0)
// ST_WAIT | request accepted, cyc held until the slave acks
module rv32i_memoryaccess #(
  localparam int OPCODE_WIDTH = 11,
  localparam int STALL_WIDTH  = 5,
  localparam int LOAD         = 2,
  localparam int STORE        = 3,
  localparam int WRITEBACK    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [31:0]             i_y,
  input  logic [31:0]             i_rs2,
  input  logic [2:0]              i_funct3,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [4:0]              i_rd_addr,
  output logic [4:0]              o_rd_addr,
  input  logic [31:0]             i_rd,
  output logic [31:0]             o_rd,
  input  logic                    i_wr_rd,
  output logic                    o_wr_rd,
  input  logic                    i_rd_valid,
  output logic                    o_rd_valid,
  input  logic [31:0]             i_pc,
  output logic [31:0]             o_pc,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic [2:0]              o_funct3,
  output logic [31:0]             o_data_load,
  output logic                    o_misaligned,
  rv32i_memoryaccess_if.master    wb,
  input  logic                    i_ce,
  output logic                    o_ce,
  input  logic [STALL_WIDTH-1:0]  i_stall,
  input  logic                    i_force_stall,
  input  logic                    i_flush,
  output logic                    o_stall,
  output logic                    o_flush
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              rd_addr_q, rd_addr_d;
  logic [31:0]             rd_q, rd_d;
  logic                    wr_rd_q, wr_rd_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [31:0]             pc_q, pc_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              addr_lo_q, addr_lo_d;
  logic [31:0]             data_load_q, data_load_d;
  logic                    misaligned_q, misaligned_d;
  logic                    ce_q, ce_d;
  logic                    flushed_q, flushed_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [31:0]             wb_addr_q, wb_addr_d;
  logic [31:0]             wb_wdata_q, wb_wdata_d;
  logic [3:0]              sel_q, sel_d;

  logic        is_load, is_store, is_access, aligned, mem_op;
  logic        pending, stall_bit, capture, ack_cycle;
  logic [31:0] st_data;
  logic [3:0]  st_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        unused_stall;

  assign is_load   = i_opcode[LOAD];
  assign is_store  = i_opcode[STORE];
  assign is_access = is_load | is_store;
  assign pending   = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign stall_bit = pending | i_stall[WRITEBACK];
  assign capture   = i_ce & ~stall_bit;
  assign mem_op    = is_access & aligned;
  // An ack is only meaningful once the request has been accepted.
  assign ack_cycle = ((state_q == ST_REQ) & ~wb.wb_stall & wb.wb_ack) |
                     ((state_q == ST_WAIT) & wb.wb_ack);
  assign unused_stall = ^i_stall;

  // Alignment check; reserved funct3 encodings fall into the word case.
  always_comb begin
    aligned = 1'b1;
    case (i_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~i_y[0];
      default: aligned = (i_y[1:0] == 2'b00);
    endcase
  end

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    st_data = i_rs2;
    st_sel  = 4'b1111;
    if (is_store) begin
      case (i_funct3[1:0])
        2'b00: begin
          st_data = {4{i_rs2[7:0]}};
          st_sel  = 4'b0001 << i_y[1:0];
        end
        2'b01: begin
          st_data = {2{i_rs2[15:0]}};
          st_sel  = i_y[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Load lane select by the held address, then sign/zero extension.
  always_comb begin
    case (addr_lo_q)
      2'd1:    ld_byte = wb.wb_rdata[15:8];
      2'd2:    ld_byte = wb.wb_rdata[23:16];
      2'd3:    ld_byte = wb.wb_rdata[31:24];
      default: ld_byte = wb.wb_rdata[7:0];
    endcase
    ld_half = addr_lo_q[1] ? wb.wb_rdata[31:16] : wb.wb_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = wb.wb_rdata;
    endcase
  end

  // Next-state, capture, bus control and o_ce sequencing.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    rd_d         = rd_q;
    wr_rd_d      = wr_rd_q;
    rd_valid_d   = rd_valid_q;
    pc_d         = pc_q;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    data_load_d  = data_load_q;
    misaligned_d = misaligned_q;
    ce_d         = ce_q;
    flushed_d    = flushed_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    wb_addr_d    = wb_addr_q;
    wb_wdata_d   = wb_wdata_q;
    sel_d        = sel_q;

    if (capture) begin
      rd_addr_d    = i_rd_addr;
      rd_d         = i_rd;
      wr_rd_d      = i_wr_rd;
      rd_valid_d   = i_rd_valid;
      pc_d         = i_pc;
      opcode_d     = i_opcode;
      funct3_d     = i_funct3;
      addr_lo_d    = i_y[1:0];
      misaligned_d = is_access & ~aligned;
      ce_d         = mem_op ? 1'b0 : ~i_flush;
      if (mem_op && !i_flush) begin
        state_d    = ST_REQ;
        cyc_d      = 1'b1;
        stb_d      = 1'b1;
        we_d       = is_store;
        wb_addr_d  = {i_y[31:2], 2'b00};
        wb_wdata_d = st_data;
        sel_d      = st_sel;
      end
    end else if (ack_cycle) begin
      // A flush seen at any point while pending discards the result.
      ce_d = ~(flushed_q | i_flush);
      if (opcode_q[LOAD]) data_load_d = ld_ext;
    end else if (!i_stall[WRITEBACK]) begin
      ce_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (!wb.wb_stall) begin
          stb_d = 1'b0;
          if (wb.wb_ack) begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wb.wb_ack) begin
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (ack_cycle)              flushed_d = 1'b0;
    else if (pending && i_flush) flushed_d = 1'b1;
  end

  // State and output registers; reset drops any open bus cycle at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      rd_q         <= '0;
      wr_rd_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      pc_q         <= '0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      data_load_q  <= '0;
      misaligned_q <= 1'b0;
      ce_q         <= 1'b0;
      flushed_q    <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      wb_addr_q    <= '0;
      wb_wdata_q   <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_q         <= rd_d;
      wr_rd_q      <= wr_rd_d;
      rd_valid_q   <= rd_valid_d;
      pc_q         <= pc_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      data_load_q  <= data_load_d;
      misaligned_q <= misaligned_d;
      ce_q         <= ce_d;
      flushed_q    <= flushed_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      wb_addr_q    <= wb_addr_d;
      wb_wdata_q   <= wb_wdata_d;
      sel_q        <= sel_d;
    end
  end

  assign o_rd_addr    = rd_addr_q;
  assign o_rd         = rd_q;
  assign o_wr_rd      = wr_rd_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_pc         = pc_q;
  assign o_opcode     = opcode_q;
  assign o_funct3     = funct3_q;
  assign o_data_load  = data_load_q;
  assign o_misaligned = misaligned_q;
  assign o_ce         = ce_q;
  assign wb.wb_cyc    = cyc_q;
  assign wb.wb_stb    = stb_q;
  assign wb.wb_we     = we_q;
  assign wb.wb_addr   = wb_addr_q;
  assign wb.wb_wdata  = wb_wdata_q;
  assign wb.wb_sel    = sel_q;
  assign o_stall      = pending | ((i_stall[WRITEBACK] | i_force_stall) & ~i_flush);
  assign o_flush      = i_flush;

endmodule

// File: tb/tb_rv32i_memoryaccess.sv
// Scoreboard bench for rv32i_memoryaccess: directed instructions, a small
// bus slave, and monitors that pop expected writeback/bus items.
module tb_rv32i_memoryaccess;
  localparam logic [10:0] OP_ADD   = 11'h001;
  localparam logic [10:0] OP_LOAD  = 11'h004;
  localparam logic [10:0] OP_STORE = 11'h008;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ce, force_stall, flush, wr_rd, rd_valid;
  logic [31:0] y, rs2, rd, pc;
  logic [2:0]  funct3;
  logic [10:0] opcode;
  logic [4:0]  rd_addr, stall;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd, o_pc, o_data_load;
  logic        o_wr_rd, o_rd_valid, o_misaligned, o_ce, o_stall, o_flush;
  logic [10:0] o_opcode;
  logic [2:0]  o_funct3;

  rv32i_memoryaccess_if bus ();

  rv32i_memoryaccess dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_y(y), .i_rs2(rs2), .i_funct3(funct3),
    .i_opcode(opcode), .i_rd_addr(rd_addr), .o_rd_addr(o_rd_addr), .i_rd(rd),
    .o_rd(o_rd), .i_wr_rd(wr_rd), .o_wr_rd(o_wr_rd), .i_rd_valid(rd_valid),
    .o_rd_valid(o_rd_valid), .i_pc(pc), .o_pc(o_pc), .o_opcode(o_opcode),
    .o_funct3(o_funct3), .o_data_load(o_data_load), .o_misaligned(o_misaligned),
    .wb(bus), .i_ce(ce), .o_ce(o_ce), .i_stall(stall),
    .i_force_stall(force_stall), .i_flush(flush), .o_stall(o_stall),
    .o_flush(o_flush)
  );

  typedef struct {
    logic [31:0] pc, rd, data;
    logic [4:0]  rd_addr;
    logic [10:0] opcode;
    logic        mis, chk_data;
    int          cyc;
  } out_t;

  typedef struct {
    logic [31:0] addr, data;
    logic [3:0]  sel;
    logic        we, chk_data;
  } bus_t;

  out_t        out_q[$];
  bus_t        bus_q[$];
  int          stb_starts[$];
  int          checks, errors, cycle, last_stb_len, stb_len;
  int          stall_cfg, ack_delay_cfg, stall_cnt, wcnt;
  logic        pend, stb_prev, inject_ack;
  logic [31:0] rdata_cfg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic bus_t mk_bus(logic [31:0] a, logic [31:0] d, logic [3:0] s, logic w, logic c);
    bus_t b;
    b.addr = a; b.data = d; b.sel = s; b.we = w; b.chk_data = c;
    return b;
  endfunction

  // Present one instruction until the stage accepts it, then idle i_ce.
  task automatic issue(input logic [10:0] op, input logic [2:0] f3, input logic [31:0] yv,
                       input logic [31:0] rs2v, input logic [31:0] rdv, input logic [31:0] pcv,
                       input logic exp_out, input int lat, input logic [31:0] ld_exp,
                       input logic chk_ld, input logic mis);
    out_t e;
    int   k;
    opcode = op; funct3 = f3; y = yv; rs2 = rs2v; rd = rdv; pc = pcv;
    rd_addr = pcv[6:2]; wr_rd = 1'b1; rd_valid = ~op[2]; ce = 1'b1;
    k = 0;
    while (o_stall && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) timeout("issue_accept");
    if (exp_out) begin
      e.pc = pcv; e.rd = rdv; e.data = ld_exp; e.rd_addr = pcv[6:2]; e.opcode = op;
      e.mis = mis; e.chk_data = chk_ld; e.cyc = (lat == 0) ? 0 : cycle + lat;
      out_q.push_back(e);
    end
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic wait_bus_idle(input string name);
    int k;
    k = 0;
    while (bus.wb_cyc && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) timeout(name);
  endtask

  initial begin
    out_t e;
    bus_t b;
    rst_n = 1'b0; ce = 1'b0; force_stall = 1'b0; flush = 1'b0; wr_rd = 1'b0; rd_valid = 1'b0;
    y = '0; rs2 = '0; rd = '0; pc = '0; funct3 = '0; opcode = '0; rd_addr = '0; stall = '0;
    bus.wb_ack = 1'b0; bus.wb_stall = 1'b0; bus.wb_rdata = '0;
    checks = 0; errors = 0; cycle = 0; last_stb_len = 0; stb_len = 0;
    stall_cfg = 0; ack_delay_cfg = 0; stall_cnt = 0; wcnt = 0; pend = 1'b0;
    stb_prev = 1'b0; inject_ack = 1'b0; rdata_cfg = '0;

    fork
      forever begin
        @(posedge clk);
        cycle++;
      end
      // Bus slave: optional stall cycles, then ack after a configurable delay.
      forever begin
        @(posedge clk);
        #2;
        bus.wb_ack   = inject_ack;
        bus.wb_rdata = rdata_cfg;
        bus.wb_stall = 1'b0;
        if (!bus.wb_cyc) begin
          stall_cnt = 0;
          pend      = 1'b0;
        end
        if (pend) begin
          if (wcnt == 0) begin
            bus.wb_ack = 1'b1;
            pend       = 1'b0;
          end else begin
            wcnt--;
          end
        end else if (bus.wb_cyc && bus.wb_stb) begin
          if (stall_cnt < stall_cfg) begin
            bus.wb_stall = 1'b1;
            stall_cnt++;
          end else begin
            pend      = 1'b1;
            wcnt      = ack_delay_cfg;
            stall_cnt = 0;
          end
        end
      end
      // Bus monitor: check each accepted request against the expected queue.
      forever begin
        @(negedge clk);
        #1;
        if (bus.wb_stb && !stb_prev) stb_starts.push_back(cycle);
        if (bus.wb_stb) stb_len++;
        else if (stb_prev) begin
          last_stb_len = stb_len;
          stb_len      = 0;
        end
        stb_prev = bus.wb_stb;
        if (rst_n && bus.wb_cyc && bus.wb_stb && !bus.wb_stall) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got addr %h expected no request", bus.wb_addr);
          end else begin
            b = bus_q.pop_front();
            chk("wb_addr", bus.wb_addr, b.addr);
            chk("wb_sel", 32'(bus.wb_sel), 32'(b.sel));
            chk("wb_we", 32'(bus.wb_we), 32'(b.we));
            if (b.chk_data) chk("wb_data", bus.wb_wdata, b.data);
          end
        end
      end
      // Writeback monitor: every o_ce pulse retires one expected instruction.
      forever begin
        @(negedge clk);
        #1;
        if (rst_n && o_ce) begin
          if (out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL o_ce_unexpected: got pc %h expected no output", o_pc);
          end else begin
            e = out_q.pop_front();
            chk("o_pc", o_pc, e.pc);
            chk("o_rd", o_rd, e.rd);
            chk("o_rd_addr", 32'(o_rd_addr), 32'(e.rd_addr));
            chk("o_opcode", 32'(o_opcode), 32'(e.opcode));
            chk("o_misaligned", 32'(o_misaligned), 32'(e.mis));
            if (e.chk_data) chk("o_data_load", o_data_load, e.data);
            if (e.cyc != 0) chk("o_ce_cycle", 32'(cycle), 32'(e.cyc));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_o_ce", 32'(o_ce), 0);
    chk("rst_cyc_stb_we", 32'({bus.wb_cyc, bus.wb_stb, bus.wb_we}), 0);
    chk("rst_sel", 32'(bus.wb_sel), 0);
    chk("rst_data_load", o_data_load, 0);
    chk("rst_misaligned", 32'(o_misaligned), 0);
    chk("rst_rd_pc", o_rd | o_pc | 32'(o_rd_addr), 0);
    chk("rst_opcode", 32'(o_opcode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD passes through with one cycle of latency
    issue(OP_ADD, 3'b000, 32'h1234, 32'h0, 32'h1234, 32'h100, 1'b1, 1, '0, 1'b0, 1'b0);
    #2;
    chk("add_bus_idle", 32'(bus.wb_cyc), 0);
    repeat (2) @(negedge clk);

    // SB at 0x1002, o_stall through the ack cycle
    bus_q.push_back(mk_bus(32'h1000, 32'hABABABAB, 4'b0100, 1'b1, 1'b1));
    issue(OP_STORE, 3'b000, 32'h1002, 32'hAB, 32'h0, 32'h104, 1'b1, 3, '0, 1'b0, 1'b0);
    #2;
    chk("sb_stall_n1", 32'(o_stall), 1);
    @(negedge clk);
    #2;
    chk("sb_stall_ack", 32'(o_stall), 1);
    @(negedge clk);
    #2;
    chk("sb_stall_after", 32'(o_stall), 0);
    repeat (2) @(negedge clk);

    // LH with two stall cycles: stb held three cycles, sign-extended
    stall_cfg = 2;
    rdata_cfg = 32'h8001_7FFF;
    bus_q.push_back(mk_bus(32'h2000, 32'h0, 4'b1111, 1'b0, 1'b0));
    issue(OP_LOAD, 3'b001, 32'h2002, 32'h0, 32'h77, 32'h108, 1'b1, 0, 32'hFFFF8001, 1'b1, 1'b0);
    wait_bus_idle("lh_idle");
    #2;
    chk("lh_stb_len", 32'(last_stb_len), 3);
    stall_cfg = 0;
    repeat (2) @(negedge clk);

    // Misaligned LW: no bus cycle, o_misaligned and o_ce next cycle
    issue(OP_LOAD, 3'b010, 32'h3001, 32'h0, 32'h5, 32'h10C, 1'b1, 1, '0, 1'b0, 1'b1);
    #2;
    chk("lw_mis_no_cyc", 32'(bus.wb_cyc), 0);
    @(negedge clk);

    // LHU at 0x3002 zero-extends the upper half
    rdata_cfg = 32'hABCD_0000;
    bus_q.push_back(mk_bus(32'h3000, 32'h0, 4'b1111, 1'b0, 1'b0));
    issue(OP_LOAD, 3'b101, 32'h3002, 32'h0, 32'h6, 32'h110, 1'b1, 3, 32'h0000ABCD, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    // Flush while waiting for ack: cycle completes, no o_ce
    ack_delay_cfg = 3;
    bus_q.push_back(mk_bus(32'h4000, 32'h0, 4'b1111, 1'b0, 1'b0));
    issue(OP_LOAD, 3'b010, 32'h4000, 32'h0, 32'h0, 32'h114, 1'b0, 0, '0, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    #2;
    chk("o_flush", 32'(o_flush), 1);
    chk("flush_cyc_held", 32'(bus.wb_cyc), 1);
    @(negedge clk);
    flush = 1'b0;
    wait_bus_idle("flush_idle");
    #2;
    chk("flush_no_ce", 32'(o_ce), 0);
    ack_delay_cfg = 0;
    @(negedge clk);
    issue(OP_ADD, 3'b000, 32'h55, 32'h0, 32'h55, 32'h118, 1'b1, 1, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a stalled request
    stall_cfg = 50;
    issue(OP_LOAD, 3'b010, 32'h5000, 32'h0, 32'h0, 32'h11C, 1'b0, 0, '0, 1'b0, 1'b0);
    #2;
    chk("req_cyc_stb", 32'({bus.wb_cyc, bus.wb_stb}), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc_stb", 32'({bus.wb_cyc, bus.wb_stb}), 0);
    chk("async_rst_stall", 32'(o_stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_cfg = 0;
    @(negedge clk);

    // Back-to-back LW/SW on zero-wait memory
    rdata_cfg = 32'h1122_3344;
    bus_q.push_back(mk_bus(32'h6004, 32'h0, 4'b1111, 1'b0, 1'b0));
    bus_q.push_back(mk_bus(32'h6008, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b1));
    issue(OP_LOAD, 3'b010, 32'h6004, 32'h0, 32'h9, 32'h120, 1'b1, 3, 32'h11223344, 1'b1, 1'b0);
    issue(OP_STORE, 3'b010, 32'h6008, 32'hDEADBEEF, 32'h0, 32'h124, 1'b1, 3, '0, 1'b0, 1'b0);
    wait_bus_idle("b2b_idle");
    repeat (2) @(negedge clk);
    if (stb_starts.size() >= 2)
      chk("b2b_stb_gap", 32'(stb_starts[stb_starts.size()-1] - stb_starts[stb_starts.size()-2]), 3);
    else
      timeout("b2b_stb_count");

    // Stray ack with no open cycle is ignored
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("stray_ack_cyc", 32'({bus.wb_cyc, bus.wb_stb}), 0);
    chk("stray_ack_ce", 32'(o_ce), 0);
    chk("stray_ack_data", o_data_load, 32'h11223344);
    @(negedge clk);
    issue(OP_ADD, 3'b000, 32'h99, 32'h0, 32'h99, 32'h128, 1'b1, 1, '0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("out_queue_empty", 32'(out_q.size()), 0);
    chk("bus_queue_empty", 32'(bus_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
